// File: rtl/ccd_seqgen.sv
// ccd_seqgen -- CCD timing sequencer.
//
// Produces the vertical/horizontal CCD phases and the AFE syncs for a
// frame-transfer sensor. A capture is one or more frames. Each frame is a
// frame transfer (XFER) followed by read lines (HFP, ACTIVE, HBP) and, when
// configured, dumped lines (LSKIP) after each read line. Every row index
// 0..vpix is consumed exactly once, either by a read line or by a dump
// sub-line, so v_cnt never passes vpix.
//
// Optional feature macro: CCDSEQ_ESHUT_EN. When defined it adds an
// electronic-shutter state (ESHUT, strobe high for cfg_ts+1 clocks) before
// every XFER, with input cfg_ts and output strobe.
//
// Ports:
//   clk, rst_n          pixel-subdivision clock, async active-low reset
//                       (assertion is immediate, release is synchronised)
//   start, stop         one-clock requests. start is only taken in IDLE and
//                       latches all cfg_* into shadow registers; stop is only
//                       taken while busy and ends capture at the next frame end.
//                       When both arrive in the same IDLE cycle, start wins.
//   cfg_*               capture configuration (sampled only on start)
//   busy, frame_done,   status: busy outside IDLE, one-clock frame-end pulse,
//   frame_cnt           frames completed in the current capture
//   hsync, vsync        AFE syncs
//   v1, v2, fdg,        CCD phases; all registered, decoded from the previous
//   h1, h2, rg          clock's state and h_cnt
module ccd_seqgen #(
    parameter int CNTW = 15,
    parameter int SUBW = 2,
    parameter int NFRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [CNTW-1:0] cfg_hpix,
    input  logic [CNTW-1:0] cfg_vpix,
    input  logic [3:0]      cfg_vskip,
    input  logic [NFRW-1:0] cfg_nframes,
    input  logic [CNTW-1:0] cfg_tvccd,
    input  logic [CNTW-1:0] cfg_thd,
    input  logic [CNTW-1:0] cfg_tfrm,
`ifdef CCDSEQ_ESHUT_EN
    input  logic [CNTW-1:0] cfg_ts,
    output logic            strobe,
`endif
    output logic            busy,
    output logic            frame_done,
    output logic [NFRW-1:0] frame_cnt,
    output logic            hsync,
    output logic            vsync,
    output logic            v1,
    output logic            v2,
    output logic            fdg,
    output logic            h1,
    output logic            h2,
    output logic            rg
);

    localparam int HW = CNTW + SUBW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_HFP,
        S_ACTIVE,
        S_HBP,
        S_LSKIP
`ifdef CCDSEQ_ESHUT_EN
        , S_ESHUT
`endif
    } state_t;

`ifdef CCDSEQ_ESHUT_EN
    localparam state_t S_FIRST = S_ESHUT;
`else
    localparam state_t S_FIRST = S_XFER;
`endif

    // Reset synchroniser: clears at once, releases two clocks later.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_core_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_core_n = rst_sync_q[1];

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [CNTW-1:0] v_cnt_q, v_cnt_d;
    logic [3:0]      sub_cnt_q, sub_cnt_d;
    logic [NFRW-1:0] frame_cnt_q, frame_cnt_d;
    logic            stop_q, stop_d;
    logic [CNTW-1:0] hpix_q, hpix_d, vpix_q, vpix_d;
    logic [CNTW-1:0] tvccd_q, tvccd_d, thd_q, thd_d, tfrm_q, tfrm_d;
    logic [3:0]      vskip_q, vskip_d;
    logic [NFRW-1:0] nframes_q, nframes_d;
`ifdef CCDSEQ_ESHUT_EN
    logic [CNTW-1:0] ts_q, ts_d;
    logic            strobe_q, strobe_d;
`endif
    logic busy_q, busy_d, frame_done_q, frame_done_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d;
    logic v1_q, v1_d, v2_q, v2_d, fdg_q, fdg_d;
    logic h1_q, h1_d, h2_q, h2_d, rg_q, rg_d;

    logic            frame_end;
    logic            line_end, xfer_end, act_end, hbp_end, in_tv;
    logic [HW:0]     h_next_w, line_len;
    logic [NFRW-1:0] frame_cnt_inc;

    // HFP and LSKIP sub-lines share the tvccd+thd length; a zero total
    // still lasts one clock rather than wrapping the counter.
    assign h_next_w      = {1'b0, h_cnt_q} + {{HW{1'b0}}, 1'b1};
    assign line_len      = {{SUBW{1'b0}}, {1'b0, tvccd_q} + {1'b0, thd_q}};
    assign line_end      = (h_next_w >= line_len);
    assign xfer_end      = (h_cnt_q == {{SUBW{1'b0}}, tfrm_q});
    assign act_end       = (h_cnt_q == {hpix_q, {SUBW{1'b1}}});
    assign hbp_end       = (h_cnt_q == {{CNTW{1'b0}}, {SUBW{1'b1}}});
    assign in_tv         = (h_cnt_q < {{SUBW{1'b0}}, tvccd_q});
    assign frame_cnt_inc = frame_cnt_q + {{(NFRW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q + {{(HW-1){1'b0}}, 1'b1};
        v_cnt_d     = v_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        hpix_d      = hpix_q;
        vpix_d      = vpix_q;
        vskip_d     = vskip_q;
        nframes_d   = nframes_q;
        tvccd_d     = tvccd_q;
        thd_d       = thd_q;
        tfrm_d      = tfrm_q;
`ifdef CCDSEQ_ESHUT_EN
        ts_d        = ts_q;
`endif
        frame_end   = 1'b0;

        if (state_q != S_IDLE && stop) stop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                h_cnt_d = '0;
                if (start) begin
                    hpix_d      = cfg_hpix;
                    vpix_d      = cfg_vpix;
                    vskip_d     = cfg_vskip;
                    nframes_d   = cfg_nframes;
                    tvccd_d     = cfg_tvccd;
                    thd_d       = cfg_thd;
                    tfrm_d      = cfg_tfrm;
`ifdef CCDSEQ_ESHUT_EN
                    ts_d        = cfg_ts;
`endif
                    frame_cnt_d = '0;
                    stop_d      = 1'b0;
                    state_d     = S_FIRST;
                end
            end
`ifdef CCDSEQ_ESHUT_EN
            S_ESHUT:  if (h_cnt_q == {{SUBW{1'b0}}, ts_q}) state_d = S_XFER;
`endif
            S_XFER:   if (xfer_end) state_d = S_HFP;
            S_HFP:    if (line_end) state_d = S_ACTIVE;
            S_ACTIVE: if (act_end)  state_d = S_HBP;
            S_HBP: begin
                if (hbp_end) begin
                    if (v_cnt_q == vpix_q) begin
                        frame_end = 1'b1;
                    end else begin
                        v_cnt_d   = v_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                        sub_cnt_d = '0;
                        state_d   = (vskip_q != 4'd0) ? S_LSKIP : S_HFP;
                    end
                end
            end
            S_LSKIP: begin
                if (line_end) begin
                    // Each sub-line dumps row v_cnt; the row equal to vpix
                    // is the last one of the frame.
                    h_cnt_d = '0;
                    if (v_cnt_q == vpix_q) begin
                        frame_end = 1'b1;
                    end else begin
                        v_cnt_d = v_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                        if (sub_cnt_q == vskip_q - 4'd1) state_d = S_HFP;
                        else sub_cnt_d = sub_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            v_cnt_d     = '0;
            frame_cnt_d = frame_cnt_inc;
            if (stop_q || (nframes_q != '0 && frame_cnt_inc == nframes_q)) state_d = S_IDLE;
            else state_d = S_FIRST;
        end

        if (state_d != state_q) h_cnt_d = '0;
    end

    // Output decode of the current state; registered below so every phase
    // lags its state/h_cnt by one clock.
    always_comb begin
        v1_d         = 1'b1;
        v2_d         = 1'b0;
        fdg_d        = 1'b0;
        h1_d         = 1'b1;
        h2_d         = 1'b0;
        hsync_d      = 1'b0;
        vsync_d      = 1'b0;
`ifdef CCDSEQ_ESHUT_EN
        strobe_d     = 1'b0;
`endif
        busy_d       = (state_q != S_IDLE);
        frame_done_d = frame_end;
        rg_d         = (state_q != S_IDLE) && (h_cnt_q[SUBW-1:0] == '0);
        case (state_q)
            S_XFER: begin
                v1_d    = 1'b0;
                v2_d    = 1'b1;
                vsync_d = 1'b1;
            end
            S_HFP: begin
                hsync_d = 1'b1;
                if (in_tv) begin
                    v1_d = 1'b0;
                    v2_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                h1_d = ~h_cnt_q[SUBW-1];
                h2_d = h_cnt_q[SUBW-1];
            end
            S_LSKIP: begin
                fdg_d = 1'b1;
                if (in_tv) begin
                    v1_d = 1'b0;
                    v2_d = 1'b1;
                end
            end
`ifdef CCDSEQ_ESHUT_EN
            S_ESHUT: strobe_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q      <= S_IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            sub_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            stop_q       <= 1'b0;
            hpix_q       <= '0;
            vpix_q       <= '0;
            vskip_q      <= '0;
            nframes_q    <= '0;
            tvccd_q      <= '0;
            thd_q        <= '0;
            tfrm_q       <= '0;
`ifdef CCDSEQ_ESHUT_EN
            ts_q         <= '0;
            strobe_q     <= 1'b0;
`endif
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            v1_q         <= 1'b1;
            v2_q         <= 1'b0;
            fdg_q        <= 1'b0;
            h1_q         <= 1'b1;
            h2_q         <= 1'b0;
            rg_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            stop_q       <= stop_d;
            hpix_q       <= hpix_d;
            vpix_q       <= vpix_d;
            vskip_q      <= vskip_d;
            nframes_q    <= nframes_d;
            tvccd_q      <= tvccd_d;
            thd_q        <= thd_d;
            tfrm_q       <= tfrm_d;
`ifdef CCDSEQ_ESHUT_EN
            ts_q         <= ts_d;
            strobe_q     <= strobe_d;
`endif
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            fdg_q        <= fdg_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            rg_q         <= rg_d;
        end
    end

`ifdef CCDSEQ_ESHUT_EN
    assign strobe     = strobe_q;
`endif
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign v1         = v1_q;
    assign v2         = v2_q;
    assign fdg        = fdg_q;
    assign h1         = h1_q;
    assign h2         = h2_q;
    assign rg         = rg_q;

endmodule

// File: doc/ccd_seqgen.md
CCD_SEQGEN -- requirements
Module: ccd_seqgen

Interface
REQ-001 The block SHALL have these parameters:
- CNTW, default 15, width of configuration counts.
- SUBW, default 2, log2 of clocks per pixel; valid range 1..3.
- NFRW, default 8, width of the frame counter.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  pixel-subdivision clock (4X pixel clock at default SUBW).
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  one-clock request to begin capture.
- stop  in  1  one-clock request to end capture at the next frame boundary.
- cfg_hpix  in  CNTW  active pixels per line minus 1.
- cfg_vpix  in  CNTW  lines per frame minus 1.
- cfg_vskip  in  4  extra lines dumped after each read line; 0 disables skipping.
- cfg_nframes  in  NFRW  frames per capture; 0 means continuous.
- cfg_tvccd  in  CNTW  vertical clock pulse width, in clocks.
- cfg_thd  in  CNTW  vertical-to-horizontal delay, in clocks.
- cfg_tfrm  in  CNTW  frame-transfer length minus 1, in clocks.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-clock pulse at each frame end.
- frame_cnt  out  NFRW  frames completed in the current capture.
- hsync, vsync  out  1 each  active-high AFE syncs.
- v1, v2, fdg, h1, h2, rg  out  1 each  active-high CCD phases.

Function
REQ-003 The state machine SHALL have the states IDLE, XFER, HFP, ACTIVE, HBP and LSKIP, plus ESHUT when the shutter option is built (REQ-017).
REQ-004 The horizontal counter h_cnt SHALL be CNTW+SUBW bits wide and SHALL clear on every state change.
REQ-005 In IDLE, a start pulse SHALL:
- latch every cfg_* input into internal shadow registers;
- clear frame_cnt and the stop flag;
- move the state to XFER.
The shadow registers SHALL hold the configuration constant for the rest of the capture.
REQ-006 XFER SHALL last cfg_tfrm+1 clocks with v1=0, v2=1 and vsync=1, then go to HFP.
REQ-007 HFP SHALL last cfg_tvccd+cfg_thd clocks:
- hsync=1 throughout;
- v1=0 and v2=1 while h_cnt<cfg_tvccd.
HFP then goes to ACTIVE.
REQ-008 ACTIVE SHALL last (cfg_hpix+1)<<SUBW clocks:
- h1=1 and h2=0 while h_cnt[SUBW-1]=0;
- h1=0 and h2=1 otherwise.
ACTIVE then goes to HBP.
REQ-009 rg SHALL be 1 when h_cnt[SUBW-1:0]==0 in every state except IDLE.
REQ-010 HBP SHALL last 2^SUBW clocks, then increment v_cnt and branch:
- if v_cnt equals vpix, end the frame;
- else if vskip≠0, go to LSKIP;
- else go to HFP.
REQ-011 LSKIP SHALL behave as follows:
- It runs sub-lines of cfg_tvccd+cfg_thd clocks each, with fdg=1 throughout and the v1/v2 pattern of HFP.
- v_cnt increments at the end of each sub-line.
- It exits to HFP after vskip sub-lines.
- If v_cnt reaches vpix first, it ends the frame instead (no overshoot).
REQ-012 At frame end the block SHALL:
- pulse frame_done for exactly one clock;
- increment frame_cnt (wrapping modulo 2^NFRW);
- clear v_cnt.
It SHALL then go to IDLE if the stop flag is set or the new frame_cnt equals nframes (nframes≠0); otherwise it SHALL go to XFER.
REQ-013 stop SHALL set a sticky flag while busy and SHALL be ignored in IDLE. start SHALL be ignored while busy. When start and stop arrive in the same IDLE cycle, start SHALL be honoured and stop dropped.
REQ-014 In IDLE the outputs SHALL be v1=1, v2=0, fdg=0, h1=1, h2=0, rg=0, hsync=0, vsync=0. Any phase not driven by the current state SHALL take its IDLE value.
REQ-015 All outputs SHALL be registered, lagging the state/h_cnt they decode by exactly one clock. Configuration inputs SHALL have no combinational path to outputs.

Reset
REQ-016 While rst_n=0, the block SHALL:
- force the state to IDLE;
- clear h_cnt, v_cnt, frame_cnt and the stop flag;
- drive every output to its REQ-014 value, with busy=0 and frame_done=0.
Reset asserted mid-frame SHALL abort immediately. Deassertion SHALL be synchronised to clk.

Configuration
REQ-017 Macro CCDSEQ_ESHUT_EN:
- Defined: adds input cfg_ts [CNTW-1:0] and output strobe (active high). An ESHUT state of cfg_ts+1 clocks, with strobe=1, precedes every XFER.
- Undefined: the ports and state are absent, and IDLE/frame-end go directly to XFER.

Verification
REQ-018 SUBW=2, hpix=3, vpix=1, vskip=0, tvccd=4, thd=4, tfrm=7, nframes=1, start -> XFER 8 clk, then 2×(HFP 8 + ACTIVE 16 + HBP 4) clk; one frame_done; busy falls; frame_cnt=1.
REQ-019 Same config but vpix=5, vskip=2 -> each read line is followed by 2 fdg=1 sub-lines of 8 clk; v_cnt reaches 5 without overshoot; 2 read lines per frame.
REQ-020 nframes=0, stop pulsed mid-frame 2 -> frame 2 completes; frame_done count=2; IDLE follows.
REQ-021 rst_n low during ACTIVE -> all outputs reach REQ-014 values asynchronously; busy=0; restart gives correct frame 1.
REQ-022 start during busy, and start+stop in the same IDLE cycle -> first ignored; second captures nframes frames.
REQ-023 CCDSEQ_ESHUT_EN defined, ts=9 -> strobe high for 10 clk before each XFER.
